// File: rtl/byte_sort_pkg.sv
// Shared types and constants for the byte sorting sequencer.
// State encoding plus the comparator carry-in that makes a single compare standalone.
package byte_sort_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Carry-in for an isolated compare: treat "everything above" as equal.
   localparam logic CMP_LT0 = 1'b0;
   localparam logic CMP_ET0 = 1'b1;
   localparam logic CMP_GT0 = 1'b0;

endpackage

// File: rtl/byte_sort_if.sv
// Producer/consumer handshake bundle for byte_sort_ctrl.
// master = the side that feeds bytes and consumes sorted bytes; slave = the sorter.
interface byte_sort_if;
   import byte_sort_pkg::*;

   logic  in_valid;
   logic  in_ready;
   byte_t in_data;
   logic  out_valid;
   logic  out_ready;
   byte_t out_data;
   logic  out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/comparator8.sv
// Cascadable unsigned 8-bit magnitude comparator.
// Equal operands pass the carry-in flags through, so chains resolve from the top slice down.
module comparator8
   import byte_sort_pkg::*;
(
   input  byte_t p,
   input  byte_t q,
   input  logic  lt_in,
   input  logic  et_in,
   input  logic  gt_in,
   output logic  lt,
   output logic  et,
   output logic  gt
);

   logic eq;

   assign eq = (p == q);
   assign lt = (p < q) | (eq & lt_in);
   assign gt = (p > q) | (eq & gt_in);
   assign et = eq & et_in;

endmodule

// File: rtl/byte_sort_ctrl.sv
// Loads DEPTH bytes, bubble-sorts them in place with one shared compare per clock,
// then streams the ordered block out; single buffer, no load/drain overlap.
module byte_sort_ctrl
   import byte_sort_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter bit DESCEND = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   byte_sort_if.slave   bus,
   output logic         busy,
   output logic [7:0]   cmp_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] LAST_CMP = IDX_W'(DEPTH - 2);

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
   logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
   logic [IDX_W-1:0] cmp_idx_reg, cmp_idx_next;
   logic [IDX_W-1:0] pass_reg, pass_next;
   logic             swap_seen_reg, swap_seen_next;
   logic [7:0]       cmp_count_reg, cmp_count_next;
   byte_t            data_reg [DEPTH];

   logic [IDX_W-1:0] cmp_idx_inc;
   byte_t            cmp_p, cmp_q;
   logic             cmp_lt, cmp_et, cmp_gt;
   logic             swap_now, swap_any;
   logic             load_fire, drain_fire;

   assign cmp_idx_inc = cmp_idx_reg + 1'b1;
   assign cmp_p       = data_reg[cmp_idx_reg];
   assign cmp_q       = data_reg[cmp_idx_inc];

   comparator8 u_cmp (
      .p     (cmp_p),
      .q     (cmp_q),
      .lt_in (CMP_LT0),
      .et_in (CMP_ET0),
      .gt_in (CMP_GT0),
      .lt    (cmp_lt),
      .et    (cmp_et),
      .gt    (cmp_gt)
   );

   // Equal bytes never swap, which keeps the sort stable.
   assign swap_now   = (state_reg == SORT) && !cmp_et && (DESCEND ? cmp_lt : cmp_gt);
   assign swap_any   = swap_seen_reg | swap_now;
   assign load_fire  = (state_reg == LOAD) && bus.in_valid;
   assign drain_fire = (state_reg == DRAIN) && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= LOAD;
         wr_idx_reg    <= '0;
         rd_idx_reg    <= '0;
         cmp_idx_reg   <= '0;
         pass_reg      <= '0;
         swap_seen_reg <= 1'b0;
         cmp_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         wr_idx_reg    <= wr_idx_next;
         rd_idx_reg    <= rd_idx_next;
         cmp_idx_reg   <= cmp_idx_next;
         pass_reg      <= pass_next;
         swap_seen_reg <= swap_seen_next;
         cmp_count_reg <= cmp_count_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      wr_idx_next    = wr_idx_reg;
      rd_idx_next    = rd_idx_reg;
      cmp_idx_next   = cmp_idx_reg;
      pass_next      = pass_reg;
      swap_seen_next = swap_seen_reg;
      cmp_count_next = cmp_count_reg;
      case (state_reg)
         LOAD: begin
            if (load_fire) begin
               if (wr_idx_reg == LAST_IDX) begin
                  wr_idx_next    = '0;
                  cmp_idx_next   = '0;
                  pass_next      = '0;
                  swap_seen_next = 1'b0;
                  cmp_count_next = '0;
                  state_next     = SORT;
               end else begin
                  wr_idx_next = wr_idx_reg + 1'b1;
               end
            end
         end
         SORT: begin
            if (cmp_count_reg != 8'hFF)
               cmp_count_next = cmp_count_reg + 8'd1;
            if (cmp_idx_reg == LAST_CMP) begin
               cmp_idx_next = '0;
               // A clean pass means sorted; DEPTH-1 passes is the bubble-sort worst case.
               if (!swap_any || (pass_reg == LAST_CMP)) begin
                  rd_idx_next = '0;
                  state_next  = DRAIN;
               end else begin
                  pass_next      = pass_reg + 1'b1;
                  swap_seen_next = 1'b0;
               end
            end else begin
               cmp_idx_next   = cmp_idx_inc;
               swap_seen_next = swap_any;
            end
         end
         DRAIN: begin
            if (drain_fire) begin
               if (rd_idx_reg == LAST_IDX) begin
                  rd_idx_next = '0;
                  wr_idx_next = '0;
                  state_next  = LOAD;
               end else begin
                  rd_idx_next = rd_idx_reg + 1'b1;
               end
            end
         end
         default: begin
            rd_idx_next = '0;
            wr_idx_next = '0;
            state_next  = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < DEPTH; j++)
            data_reg[j] <= '0;
      end else if (load_fire) begin
         data_reg[wr_idx_reg] <= bus.in_data;
      end else if (swap_now) begin
         data_reg[cmp_idx_reg] <= cmp_q;
         data_reg[cmp_idx_inc] <= cmp_p;
      end
   end

   assign bus.in_ready  = (state_reg == LOAD);
   assign bus.out_valid = (state_reg == DRAIN);
   assign bus.out_data  = (state_reg == DRAIN) ? data_reg[rd_idx_reg] : '0;
   assign bus.out_last  = (state_reg == DRAIN) && (rd_idx_reg == LAST_IDX);
   assign busy          = (state_reg == SORT) || (state_reg == DRAIN);
   assign cmp_count     = cmp_count_reg;

endmodule
